// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and width helper for param_sync_fifo and its storage.
package param_sync_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_AF_LEVEL   = DEF_DEPTH - 2;
   localparam int DEF_AE_LEVEL   = 2;

   // One extra bit beyond the address so full and empty can be told apart
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage for param_sync_fifo: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]      rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with occupancy count, almost flags and over/underflow pulses.
// Define FIFO_FWFT_EN for first-word fall-through output; default is registered one-cycle read.
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          wr_en,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [ptr_width(DEPTH)-1:0]   data_count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // A full FIFO with both requests pops only; an empty one pushes only
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   assign almost_full  = (data_count >= PW'(AF_LEVEL));
   assign almost_empty = (data_count <= PW'(AE_LEVEL));

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (din),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         if (wr_acc && !rd_acc)      data_count <= data_count + PW'(1);
         else if (rd_acc && !wr_acc) data_count <= data_count - PW'(1);
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

`ifdef FIFO_FWFT_EN
   assign dout = empty ? '0 : ram_rdata;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout <= '0;
      else if (rd_acc) dout <= ram_rdata;
   end
`endif

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (1..DEPTH-1, < AF_LEVEL).
REQ-005 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port din  input  DATA_WIDTH  write data.
REQ-008 The block SHALL have port wr_en  input  1  write request.
REQ-009 The block SHALL have port rd_en  input  1  read request.
REQ-010 The block SHALL have port dout  output  DATA_WIDTH  read data.
REQ-011 The block SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-012 The block SHALL have port data_count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-013 The block SHALL have ports overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-014 Write SHALL be accepted iff wr_en && !full; din is stored at the write pointer on that edge.
REQ-015 Read SHALL be accepted iff rd_en && !empty; the head entry is popped on that edge.
REQ-016 Pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full = MSBs differ and the other bits are equal; empty = pointers equal.
REQ-017 data_count SHALL increment on write-only, decrement on read-only, and hold when both are accepted or neither is.
REQ-018 Flags SHALL derive from registered state: almost_full = (data_count >= AF_LEVEL), almost_empty = (data_count <= AE_LEVEL); all flags are valid the cycle after the causing edge.
REQ-019 When full with wr_en && rd_en, the read SHALL be accepted, the write rejected, and overflow pulses.
REQ-020 When empty with wr_en && rd_en, the write SHALL be accepted, the read rejected, and underflow pulses.
REQ-021 overflow SHALL pulse high for one cycle after any rejected write; underflow SHALL pulse high for one cycle after any rejected read.
REQ-022 Standard mode: dout SHALL be registered and present the popped word one cycle after the accepting edge, holding its value otherwise.
REQ-023 Rejected operations SHALL leave pointers, count and memory unchanged.

Reset
REQ-024 rst_n low SHALL immediately clear pointers and data_count and set dout=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-025 Reset mid-operation SHALL discard all contents; memory array is not cleared, and no stale word is visible after reset.
REQ-026 Reset deassertion SHALL be synchronised to clk externally; the first operation is permitted on the first edge after deassertion.

Configuration
REQ-027 With macro FIFO_FWFT_EN defined, dout SHALL show the head entry combinationally whenever !empty (first-word fall-through), rd_en acknowledges/pops it, and dout=0 while empty.
REQ-028 Without FIFO_FWFT_EN, read latency SHALL be one cycle per REQ-022.

Structure
REQ-029 Package param_sync_fifo_pkg SHALL hold the default-parameter constants and a function returning the pointer/count width from DEPTH.
REQ-030 Storage SHALL be the sub-module fifo_ram (one write port, one read port, DATA_WIDTH x DEPTH, no reset); control, pointers and flags reside in param_sync_fifo.

Verification (DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-031 Write 0x01..0x10, then read 16 -> full after write 16, dout 0x01..0x10 in order with one-cycle latency, empty after last read.
REQ-032 Fill 16, then wr_en with din=0xAA while full -> overflow pulse for one cycle, data_count=16, 0xAA never read back.
REQ-033 Empty FIFO, rd_en=1 -> underflow pulse, data_count=0, dout unchanged.
REQ-034 Occupancy 8, wr_en && rd_en for 100 cycles with random data -> data_count stays 8, output order matches a golden queue, pointers wrap repeatedly.
REQ-035 Fill to 13, 14, 3, 2 -> almost_full toggles 0->1 at 14; almost_empty toggles 0->1 at 2.
REQ-036 Assert rst_n=0 at occupancy 9 mid-burst -> flags/count/dout go to reset values immediately; after release, write 0x55 then read -> dout=0x55 (FWFT build: dout=0x55 the cycle after the write).
